// File: rtl/macc_cmd_issue_if.sv
// macc_cmd_issue_if: the bus bundle around the macc_cmd_issue sequencer.
//   cmd_*  : command channel (valid/ready) into the sequencer
//   ab_* / ai / bj / ci_valid / cld_addr / ci / cst_addr / co : macc_cell ports
//   rsp_*  : STORE_C read-back channel (valid/ready) out of the sequencer
// Modport slave is the sequencer's view; master is the surrounding
// environment (command source, cell, response sink).
interface macc_cmd_issue_if #(
  parameter int nregs = 2,
  parameter int XLEN  = 64
);
  localparam int AW = (nregs > 1) ? $clog2(nregs) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [XLEN-1:0] cmd_a;
  logic [XLEN-1:0] cmd_b;

  logic            ab_valid;
  logic [AW-1:0]   ab_addr;
  logic [XLEN-1:0] ai;
  logic [XLEN-1:0] bj;
  logic            ci_valid;
  logic [AW-1:0]   cld_addr;
  logic [XLEN-1:0] ci;
  logic [AW-1:0]   cst_addr;
  logic [XLEN-1:0] co;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_a, cmd_b, co, rsp_ready,
    output cmd_ready, ab_valid, ab_addr, ai, bj, ci_valid, cld_addr, ci,
           cst_addr, rsp_valid, rsp_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_a, cmd_b, co, rsp_ready,
    input  cmd_ready, ab_valid, ab_addr, ai, bj, ci_valid, cld_addr, ci,
           cst_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/macc_cmd_issue.sv
// macc_cmd_issue: in-order command sequencer in front of one macc_cell.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   bus (slave)      : command channel, cell strobes, STORE_C response channel
//   busy             : a command or response is still in flight
//   err              : sticky, an illegal opcode was consumed
//   stat_macc_cnt    : number of MACCs issued (wraps)
// Commands go through a DEPTH-entry FIFO, are popped one per cycle into a
// registered issue stage that drives the cell, and STORE_C results are
// captured from co into a 2-entry response FIFO.
module macc_cmd_issue #(
  parameter int nregs = 2,
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  macc_cmd_issue_if.slave bus,
  output logic            busy,
  output logic            err,
  output logic [31:0]     stat_macc_cnt
);
  localparam int AW = (nregs > 1) ? $clog2(nregs) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_MACC  = 2'd1,
    OP_STORE = 2'd2,
    OP_ILL   = 2'd3
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } cmd_t;

  cmd_t            fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic            cmd_ready_q;
  cmd_t            in_s, head_s;
  logic            push_s, pop_s, store_ok_s;
  logic [2:0]      rsp_proj_s;

  logic            iss_valid_q, iss_valid_d;
  logic            iss_store_q, iss_store_d;
  logic            ab_valid_q, ab_valid_d;
  logic [AW-1:0]   ab_addr_q, ab_addr_d;
  logic [XLEN-1:0] ai_q, ai_d, bj_q, bj_d;
  logic            ci_valid_q, ci_valid_d;
  logic [AW-1:0]   cld_addr_q, cld_addr_d;
  logic [XLEN-1:0] ci_q, ci_d;
  logic [AW-1:0]   cst_addr_q, cst_addr_d;
  logic            err_q, err_d;
  logic [31:0]     stat_q, stat_d;

  logic [XLEN-1:0] rsp_mem_q [2];
  logic            rsp_wp_q, rsp_rp_q;
  logic [1:0]      rsp_cnt_q, rsp_cnt_d;
  logic            rsp_valid_q, rsp_pop_s;
  logic            busy_q;

  // Pack the incoming command and pick out the FIFO head.
  always_comb begin
    in_s.op   = op_e'(bus.cmd_op);
    in_s.addr = bus.cmd_addr;
    in_s.a    = bus.cmd_a;
    in_s.b    = bus.cmd_b;
    head_s    = fifo_q[rd_ptr_q];
  end

  assign push_s    = bus.cmd_valid & cmd_ready_q;
  assign rsp_pop_s = rsp_valid_q & bus.rsp_ready;
  // Responses held at the end of this cycle: a STORE popped now lands one
  // cycle later, so it may only go if this projection leaves a free slot.
  assign rsp_proj_s = {1'b0, rsp_cnt_q} + {2'b00, iss_store_q} - {2'b00, rsp_pop_s};
  assign store_ok_s = (rsp_proj_s < 3'd2);

  // Head pop decision: stores wait for response space, everything else goes.
  always_comb begin
    pop_s = 1'b0;
    if (fifo_cnt_q != {CW{1'b0}}) begin
      if (head_s.op == OP_STORE) begin
        pop_s = store_ok_s;
      end else begin
        pop_s = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Command FIFO occupancy next state.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Command FIFO pointers, count and registered ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      fifo_cnt_q  <= {CW{1'b0}};
      cmd_ready_q <= 1'b1;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q  <= fifo_cnt_d;
      cmd_ready_q <= (fifo_cnt_d < CW'(DEPTH));
    end
  end

  // Command FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) fifo_q[wr_ptr_q] <= in_s;
  end

  // Issue stage next state: strobes are single-cycle, payloads hold.
  always_comb begin
    iss_valid_d = pop_s;
    iss_store_d = 1'b0;
    ab_valid_d  = 1'b0;
    ci_valid_d  = 1'b0;
    ab_addr_d   = ab_addr_q;
    ai_d        = ai_q;
    bj_d        = bj_q;
    cld_addr_d  = cld_addr_q;
    ci_d        = ci_q;
    cst_addr_d  = cst_addr_q;
    err_d       = err_q;
    stat_d      = stat_q;
    if (pop_s) begin
      case (head_s.op)
        OP_LOAD: begin
          ci_valid_d = 1'b1;
          cld_addr_d = head_s.addr;
          ci_d       = head_s.a;
        end
        OP_MACC: begin
          ab_valid_d = 1'b1;
          ab_addr_d  = head_s.addr;
          ai_d       = head_s.a;
          bj_d       = head_s.b;
          stat_d     = stat_q + 32'd1;
        end
        OP_STORE: begin
          iss_store_d = 1'b1;
          cst_addr_d  = head_s.addr;
        end
        default: err_d = 1'b1;
      endcase
    end else begin
      iss_valid_d = 1'b0;
    end
  end

  // Issue stage and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iss_valid_q <= 1'b0;
      iss_store_q <= 1'b0;
      ab_valid_q  <= 1'b0;
      ab_addr_q   <= {AW{1'b0}};
      ai_q        <= {XLEN{1'b0}};
      bj_q        <= {XLEN{1'b0}};
      ci_valid_q  <= 1'b0;
      cld_addr_q  <= {AW{1'b0}};
      ci_q        <= {XLEN{1'b0}};
      cst_addr_q  <= {AW{1'b0}};
      err_q       <= 1'b0;
      stat_q      <= 32'd0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_store_q <= iss_store_d;
      ab_valid_q  <= ab_valid_d;
      ab_addr_q   <= ab_addr_d;
      ai_q        <= ai_d;
      bj_q        <= bj_d;
      ci_valid_q  <= ci_valid_d;
      cld_addr_q  <= cld_addr_d;
      ci_q        <= ci_d;
      cst_addr_q  <= cst_addr_d;
      err_q       <= err_d;
      stat_q      <= stat_d;
    end
  end

  // Response FIFO occupancy next state; push comes from a STORE in issue.
  always_comb begin
    rsp_cnt_d = rsp_cnt_q;
    case ({iss_store_q, rsp_pop_s})
      2'b10:   rsp_cnt_d = rsp_cnt_q + 2'd1;
      2'b01:   rsp_cnt_d = rsp_cnt_q - 2'd1;
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  // Response FIFO storage, pointers, valid flag and busy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_mem_q[0] <= {XLEN{1'b0}};
      rsp_mem_q[1] <= {XLEN{1'b0}};
      rsp_wp_q     <= 1'b0;
      rsp_rp_q     <= 1'b0;
      rsp_cnt_q    <= 2'd0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (iss_store_q) begin
        rsp_mem_q[rsp_wp_q] <= bus.co;
        rsp_wp_q            <= ~rsp_wp_q;
      end
      if (rsp_pop_s) rsp_rp_q <= ~rsp_rp_q;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_valid_q <= (rsp_cnt_d != 2'd0);
      busy_q      <= (fifo_cnt_d != {CW{1'b0}}) | iss_valid_d | (rsp_cnt_d != 2'd0);
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.ab_valid   = ab_valid_q;
  assign bus.ab_addr    = ab_addr_q;
  assign bus.ai         = ai_q;
  assign bus.bj         = bj_q;
  assign bus.ci_valid   = ci_valid_q;
  assign bus.cld_addr   = cld_addr_q;
  assign bus.ci         = ci_q;
  assign bus.cst_addr   = cst_addr_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_mem_q[rsp_rp_q];
  assign busy           = busy_q;
  assign err            = err_q;
  assign stat_macc_cnt  = stat_q;
endmodule
